// File: rtl/alu_exec_issue_if.sv
// rtl/alu_exec_issue_if.sv - ID-side, ALU-side and write-back signal bundle for alu_exec_issue
// Ports (slave = issue stage view):
//   in_*   : decoded instruction from ID, valid/ready handshake (in_ready driven by stage)
//   fwd_*  : write-back bus used for operand forwarding
//   out_*  : registered operands/control to the ALU, valid/ready handshake (out_ready from ALU)
//   err_illegal : one-cycle pulse after an illegal R-type funct is accepted
interface alu_exec_issue_if #(
    parameter int WIDTH = 48,
    parameter int RADDR = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_aluop;
    logic [5:0]       in_funct;
    logic [RADDR-1:0] in_rs_addr;
    logic [RADDR-1:0] in_rt_addr;
    logic [RADDR-1:0] in_rd_addr;
    logic [WIDTH-1:0] in_rs_val;
    logic [WIDTH-1:0] in_rt_val;
    logic [WIDTH-1:0] in_imm;
    logic             in_use_imm;
    logic             fwd_valid;
    logic [RADDR-1:0] fwd_addr;
    logic [WIDTH-1:0] fwd_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [3:0]       out_control;
    logic [RADDR-1:0] out_rd_addr;
    logic             err_illegal;

    modport slave (
        input  in_valid, in_aluop, in_funct, in_rs_addr, in_rt_addr, in_rd_addr,
        input  in_rs_val, in_rt_val, in_imm, in_use_imm,
        input  fwd_valid, fwd_addr, fwd_data,
        input  out_ready,
        output in_ready, out_valid, out_a, out_b, out_control, out_rd_addr, err_illegal
    );

    modport master (
        output in_valid, in_aluop, in_funct, in_rs_addr, in_rt_addr, in_rd_addr,
        output in_rs_val, in_rt_val, in_imm, in_use_imm,
        output fwd_valid, fwd_addr, fwd_data,
        output out_ready,
        input  in_ready, out_valid, out_a, out_b, out_control, out_rd_addr, err_illegal
    );
endinterface

// File: rtl/alu_exec_issue.sv
// rtl/alu_exec_issue.sv - execute-issue stage: ALU control decode, operand select, forwarding, 2-entry skid buffer
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : alu_exec_issue_if.slave (in_* from ID, fwd_* from write-back, out_* to ALU, err_illegal)
// Optional feature: define ALU_ISSUE_FWD_EN to enable write-back forwarding at acceptance and
// snooping of held entries; without it the fwd_* signals are ignored.
module alu_exec_issue #(
    parameter int WIDTH = 48,
    parameter int RADDR = 5
) (
    input logic             clk,
    input logic             rst,
    alu_exec_issue_if.slave bus
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       ctrl;
        logic [RADDR-1:0] rd;
`ifdef ALU_ISSUE_FWD_EN
        logic [RADDR-1:0] rs;
        logic [RADDR-1:0] rt;
        logic             b_imm;
`endif
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t new_e;
    entry_t main_s;
    entry_t skid_s;
    logic   in_ready_q;
    logic   err_q, err_d;
    logic   main_valid;
    logic   accept;
    logic   xfer;
    logic [4:0] dec;

    // Returns {illegal, control}.
    function automatic logic [4:0] decode(input logic [1:0] aluop, input logic [5:0] funct);
        logic [4:0] r;
        case (aluop)
            2'b00: r = {1'b0, 4'h2};
            2'b01: r = {1'b0, 4'h6};
            2'b11: r = {1'b0, 4'h1};
            default: begin
                case (funct)
                    6'h20:   r = {1'b0, 4'h2};
                    6'h22:   r = {1'b0, 4'h6};
                    6'h24:   r = {1'b0, 4'h0};
                    6'h25:   r = {1'b0, 4'h1};
                    6'h2A:   r = {1'b0, 4'h7};
                    6'h27:   r = {1'b0, 4'hC};
                    default: r = {1'b1, 4'hF};
                endcase
            end
        endcase
        return r;
    endfunction

`ifdef ALU_ISSUE_FWD_EN
    // Apply one write-back to an entry; register 0 and immediate B are never replaced.
    function automatic entry_t snoop(input entry_t e, input logic fv,
                                     input logic [RADDR-1:0] fa, input logic [WIDTH-1:0] fd);
        entry_t r;
        r = e;
        if (fv && (fa == e.rs) && (e.rs != '0)) begin
            r.a = fd;
        end
        if (fv && !e.b_imm && (fa == e.rt) && (e.rt != '0)) begin
            r.b = fd;
        end
        return r;
    endfunction
`endif

    assign main_valid = (state_q != ST_EMPTY);
    assign accept     = bus.in_valid && in_ready_q;
    assign xfer       = main_valid && bus.out_ready;
    assign dec        = decode(bus.in_aluop, bus.in_funct);

    // Candidate entry from ID and forwarded views of the held entries.
    always_comb begin
        new_e      = '0;
        new_e.a    = bus.in_rs_val;
        new_e.b    = bus.in_use_imm ? bus.in_imm : bus.in_rt_val;
        new_e.ctrl = dec[3:0];
        new_e.rd   = bus.in_rd_addr;
        main_s     = main_q;
        skid_s     = skid_q;
`ifdef ALU_ISSUE_FWD_EN
        new_e.rs    = bus.in_rs_addr;
        new_e.rt    = bus.in_rt_addr;
        new_e.b_imm = bus.in_use_imm;
        new_e       = snoop(new_e, bus.fwd_valid, bus.fwd_addr, bus.fwd_data);
        main_s      = snoop(main_q, bus.fwd_valid, bus.fwd_addr, bus.fwd_data);
        skid_s      = snoop(skid_q, bus.fwd_valid, bus.fwd_addr, bus.fwd_data);
`endif
    end

    // Skid-buffer occupancy: ONE with simultaneous accept and transfer refills main directly.
    always_comb begin
        state_d = state_q;
        main_d  = main_s;
        skid_d  = skid_s;
        err_d   = accept && dec[4];
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = new_e;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    main_d = new_e;
                end else if (accept) begin
                    skid_d  = new_e;
                    state_d = ST_TWO;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (xfer) begin
                    main_d  = skid_s;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            // Registered ready: low exactly while both slots are occupied.
            in_ready_q <= (state_d != ST_TWO);
            err_q      <= err_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = main_valid;
    assign bus.out_a       = main_q.a;
    assign bus.out_b       = main_q.b;
    assign bus.out_control = main_q.ctrl;
    assign bus.out_rd_addr = main_q.rd;
    assign bus.err_illegal = err_q;

endmodule
